// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: fetch/decode/exec/mem/writeback sequencing with a sticky
// illegal-opcode halt. Control outputs are combinational from the current state and instr.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  alu_op,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        illegal
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [6:0] opcode;
    logic [4:0] rd;
    logic       legal;
    logic [1:0] dec_a_sel;
    logic       dec_b_sel;
    logic [1:0] dec_alu_op;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign rd                = instr[11:7];
    assign unused_instr_bits = ^instr[31:12];
    assign legal = opcode inside {OpR, OpImm, OpLoad, OpStore, OpBranch,
                                  OpLui, OpAuipc, OpJal, OpJalr};

    // ALU operand/op selection depends only on the opcode, so it stays stable from EXEC to WB.
    always_comb begin
        dec_a_sel  = 2'd0;
        dec_b_sel  = 1'b0;
        dec_alu_op = 2'd0;
        case (opcode)
            OpR:                      dec_alu_op = 2'd1;
            OpImm: begin
                dec_b_sel  = 1'b1;
                dec_alu_op = 2'd1;
            end
            OpLoad, OpStore, OpJalr:  dec_b_sel = 1'b1;
            OpLui: begin
                dec_a_sel = 2'd2;
                dec_b_sel = 1'b1;
            end
            OpAuipc, OpJal: begin
                dec_a_sel = 2'd1;
                dec_b_sel = 1'b1;
            end
            OpBranch:                 dec_alu_op = 2'd2;
            default:                  ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = 2'd0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        alu_a_sel    = 2'd0;
        alu_b_sel    = 1'b0;
        alu_op       = 2'd0;
        rf_we        = 1'b0;
        wb_sel       = 2'd0;
        // Reset masks every control output in the same cycle, not only after the edge.
        if (rst_n) begin
            unique case (state_q)
                StFetch: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        state_d  = StDecode;
                    end
                end
                StDecode: begin
                    if (legal) begin
                        state_d = StExec;
                    end else begin
                        state_d   = StHalt;
                        illegal_d = 1'b1;
                    end
                end
                StExec: begin
                    alu_a_sel = dec_a_sel;
                    alu_b_sel = dec_b_sel;
                    alu_op    = dec_alu_op;
                    if (opcode == OpBranch) begin
                        pc_write = 1'b1;
                        pc_sel   = {1'b0, br_taken};
                        state_d  = StFetch;
                    end else if (opcode == OpLoad || opcode == OpStore) begin
                        state_d = StMem;
                    end else begin
                        state_d = StWb;
                    end
                end
                StMem: begin
                    alu_a_sel    = dec_a_sel;
                    alu_b_sel    = dec_b_sel;
                    alu_op       = dec_alu_op;
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (opcode == OpStore);
                    if (mem_ready) begin
                        if (opcode == OpStore) begin
                            pc_write = 1'b1;
                            state_d  = StFetch;
                        end else begin
                            state_d = StWb;
                        end
                    end
                end
                StWb: begin
                    alu_a_sel = dec_a_sel;
                    alu_b_sel = dec_b_sel;
                    alu_op    = dec_alu_op;
                    rf_we     = (rd != 5'd0);
                    pc_write  = 1'b1;
                    if (opcode == OpLoad) begin
                        wb_sel = 2'd1;
                    end else if (opcode == OpJal || opcode == OpJalr) begin
                        wb_sel = 2'd2;
                    end
                    if (opcode == OpJal) begin
                        pc_sel = 2'd1;
                    end else if (opcode == OpJalr) begin
                        pc_sel = 2'd2;
                    end
                    state_d = StFetch;
                end
                StHalt:  state_d = StHalt;
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed table, reset/halt corner sequences and a randomized
// instruction stream, all compared cycle by cycle against a phase-level reference model.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        br_taken;
    logic        ir_write, pc_write, mem_req, mem_we, mem_addr_sel, alu_b_sel, rf_we, illegal;
    logic [1:0]  pc_sel, alu_a_sel, alu_op, wb_sel;
    logic [2:0]  state;

    multicycle_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .br_taken     (br_taken),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_sel       (pc_sel),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .alu_op       (alu_op),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .state        (state),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_sel;
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic [1:0] alu_a_sel;
        logic       alu_b_sel;
        logic [1:0] alu_op;
        logic       rf_we;
        logic [1:0] wb_sel;
    } ctrl_t;

    typedef struct packed {
        logic [2:0] state;
        logic       illegal;
        ctrl_t      ctrl;
    } obs_t;

    typedef struct {
        logic mem_ready;
        logic br_taken;
        obs_t exp;
    } step_t;

    typedef struct {
        logic [31:0] ins;
        int          fw;
        int          mw;
        logic        br;
        int          cycles;
        logic [1:0]  pc_sel;
        logic        rf_we;
        logic [1:0]  wb_sel;
    } vec_t;

    localparam int KR = 0, KI = 1, KLd = 2, KSt = 3, KBr = 4, KLui = 5, KAuipc = 6, KJal = 7,
                   KJalr = 8, KBad = 9;

    int    nvec = 0;
    int    nerr = 0;
    step_t trace[$];
    vec_t  tbl[11];

    function automatic obs_t mk(input logic [2:0] st, input logic il);
        obs_t o;
        o         = '0;
        o.state   = st;
        o.illegal = il;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.state              = state;
        o.illegal            = illegal;
        o.ctrl.ir_write      = ir_write;
        o.ctrl.pc_write      = pc_write;
        o.ctrl.pc_sel        = pc_sel;
        o.ctrl.mem_req       = mem_req;
        o.ctrl.mem_we        = mem_we;
        o.ctrl.mem_addr_sel  = mem_addr_sel;
        o.ctrl.alu_a_sel     = alu_a_sel;
        o.ctrl.alu_b_sel     = alu_b_sel;
        o.ctrl.alu_op        = alu_op;
        o.ctrl.rf_we         = rf_we;
        o.ctrl.wb_sel        = wb_sel;
        return o;
    endfunction

    function automatic int kind_of(input logic [6:0] op);
        case (op)
            7'b0110011: return KR;
            7'b0010011: return KI;
            7'b0000011: return KLd;
            7'b0100011: return KSt;
            7'b1100011: return KBr;
            7'b0110111: return KLui;
            7'b0010111: return KAuipc;
            7'b1101111: return KJal;
            7'b1100111: return KJalr;
            default:    return KBad;
        endcase
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act  = sample();
        nvec = nvec + 1;
        if (act !== exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got state/illegal/ctrl %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        nvec = nvec + 1;
        if (act != exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference model: expand one instruction into its per-cycle phases.
    task automatic build(input logic [31:0] ins, input int fw, input int mw, input logic br,
                         input int halt_cycles);
        step_t s;
        int    k;
        logic [1:0] a;
        logic       b;
        logic [1:0] op;
        trace.delete();
        k = kind_of(ins[6:0]);
        a = (k == KLui) ? 2'd2 : (k == KAuipc || k == KJal) ? 2'd1 : 2'd0;
        b = !(k == KR || k == KBr);
        op = (k == KR || k == KI) ? 2'd1 : (k == KBr) ? 2'd2 : 2'd0;
        for (int i = 0; i <= fw; i++) begin
            s.mem_ready = (i == fw);
            s.br_taken = rbit();
            s.exp = mk(3'd0, 1'b0);
            s.exp.ctrl.mem_req = 1'b1;
            s.exp.ctrl.ir_write = (i == fw);
            trace.push_back(s);
        end
        s.mem_ready = rbit();
        s.br_taken = rbit();
        s.exp = mk(3'd1, 1'b0);
        trace.push_back(s);
        if (k == KBad) begin
            for (int i = 0; i < halt_cycles; i++) begin
                s.mem_ready = rbit();
                s.br_taken = rbit();
                s.exp = mk(3'd5, 1'b1);
                trace.push_back(s);
            end
            return;
        end
        s.mem_ready = rbit();
        s.br_taken = (k == KBr) ? br : rbit();
        s.exp = mk(3'd2, 1'b0);
        s.exp.ctrl.alu_a_sel = a;
        s.exp.ctrl.alu_b_sel = b;
        s.exp.ctrl.alu_op = op;
        if (k == KBr) begin
            s.exp.ctrl.pc_write = 1'b1;
            s.exp.ctrl.pc_sel = {1'b0, br};
            trace.push_back(s);
            return;
        end
        trace.push_back(s);
        if (k == KLd || k == KSt) begin
            for (int i = 0; i <= mw; i++) begin
                s.mem_ready = (i == mw);
                s.br_taken = rbit();
                s.exp = mk(3'd3, 1'b0);
                s.exp.ctrl.alu_a_sel = a;
                s.exp.ctrl.alu_b_sel = b;
                s.exp.ctrl.alu_op = op;
                s.exp.ctrl.mem_req = 1'b1;
                s.exp.ctrl.mem_addr_sel = 1'b1;
                s.exp.ctrl.mem_we = (k == KSt);
                s.exp.ctrl.pc_write = (k == KSt) && (i == mw);
                trace.push_back(s);
            end
            if (k == KSt) return;
        end
        s.mem_ready = rbit();
        s.br_taken = rbit();
        s.exp = mk(3'd4, 1'b0);
        s.exp.ctrl.alu_a_sel = a;
        s.exp.ctrl.alu_b_sel = b;
        s.exp.ctrl.alu_op = op;
        s.exp.ctrl.rf_we = (ins[11:7] != 5'd0);
        s.exp.ctrl.wb_sel = (k == KLd) ? 2'd1 : (k == KJal || k == KJalr) ? 2'd2 : 2'd0;
        s.exp.ctrl.pc_write = 1'b1;
        s.exp.ctrl.pc_sel = (k == KJal) ? 2'd1 : (k == KJalr) ? 2'd2 : 2'd0;
        trace.push_back(s);
    endtask

    // Drive the current trace; optionally assert reset at step abort_at and stop there.
    task automatic apply(input string name, input logic [31:0] ins, input int abort_at,
                         output int pcw_cycle, output ctrl_t last);
        obs_t e;
        pcw_cycle = -1;
        last = '0;
        instr = ins;
        for (int i = 0; i < trace.size(); i++) begin
            mem_ready = trace[i].mem_ready;
            br_taken = trace[i].br_taken;
            e = trace[i].exp;
            if (i == abort_at) begin
                rst_n = 1'b0;
                e.ctrl = '0;
            end
            #1;
            check($sformatf("%s[%0d]", name, i), e);
            if (pc_write === 1'b1 && pcw_cycle < 0) begin
                pcw_cycle = i;
                last = sample().ctrl;
            end
            @(posedge clk);
            #1;
            if (i == abort_at) begin
                rst_n = 1'b1;
                return;
            end
        end
    endtask

    task automatic reset_cycle(input string name, input logic [2:0] st, input logic il);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check(name, mk(st, il));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        begin
            obs_t e;
            e = mk(3'd0, 1'b0);
            e.ctrl.mem_req = 1'b1;
            check({name, "_release"}, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        int    pcw;
        ctrl_t last;
        logic [6:0] ops [9];
        tbl[0]  = '{32'h00500093, 0, 0, 1'b0, 4, 2'd0, 1'b1, 2'd0};
        tbl[1]  = '{32'h0000A103, 0, 2, 1'b0, 7, 2'd0, 1'b1, 2'd1};
        tbl[2]  = '{32'h00208463, 0, 0, 1'b1, 3, 2'd1, 1'b0, 2'd0};
        tbl[3]  = '{32'h00208463, 0, 0, 1'b0, 3, 2'd0, 1'b0, 2'd0};
        tbl[4]  = '{32'h00000013, 0, 0, 1'b0, 4, 2'd0, 1'b0, 2'd0};
        tbl[5]  = '{32'h008000EF, 0, 0, 1'b0, 4, 2'd1, 1'b1, 2'd2};
        tbl[6]  = '{32'h000080E7, 0, 0, 1'b0, 4, 2'd2, 1'b1, 2'd2};
        tbl[7]  = '{32'h0020A023, 1, 1, 1'b0, 6, 2'd0, 1'b0, 2'd0};
        tbl[8]  = '{32'h000052B7, 2, 0, 1'b0, 6, 2'd0, 1'b1, 2'd0};
        tbl[9]  = '{32'h00000297, 0, 0, 1'b0, 4, 2'd0, 1'b1, 2'd0};
        tbl[10] = '{32'h002081B3, 0, 0, 1'b0, 4, 2'd0, 1'b1, 2'd0};
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

        rst_n = 1'b0;
        instr = '0;
        mem_ready = 1'b1;
        br_taken = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", mk(3'd0, 1'b0));
        rst_n = 1'b1;

        foreach (tbl[v]) begin
            build(tbl[v].ins, tbl[v].fw, tbl[v].mw, tbl[v].br, 0);
            apply($sformatf("vec%0d", v), tbl[v].ins, -1, pcw, last);
            check_int($sformatf("vec%0d_cycles", v), pcw + 1, tbl[v].cycles);
            check_int($sformatf("vec%0d_pc_sel", v), int'(last.pc_sel), int'(tbl[v].pc_sel));
            check_int($sformatf("vec%0d_rf_we", v), int'(last.rf_we), int'(tbl[v].rf_we));
            check_int($sformatf("vec%0d_wb_sel", v), int'(last.wb_sel), int'(tbl[v].wb_sel));
            reset_cycle($sformatf("vec%0d_reset", v), 3'd0, 1'b0);
        end

        // Illegal opcode parks in HALT with the sticky flag until a single reset edge.
        build(32'hFFFFFFFF, 1, 0, 1'b0, 12);
        apply("illegal", 32'hFFFFFFFF, -1, pcw, last);
        check_int("illegal_no_pc_write", pcw, -1);
        reset_cycle("halt_reset", 3'd5, 1'b1);

        // Reset in the middle of a stalled store: request drops at once, no PC update.
        build(32'h0020A023, 0, 3, 1'b0, 0);
        apply("sw_abort", 32'h0020A023, 4, pcw, last);
        check_int("sw_abort_no_pc_write", pcw, -1);
        begin
            obs_t e;
            mem_ready = 1'b0;
            #1;
            e = mk(3'd0, 1'b0);
            e.ctrl.mem_req = 1'b1;
            check("sw_abort_after", e);
        end

        // Back-to-back random instructions with random wait states and ignored-input noise.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] ins;
            ins = {$urandom()};
            ins[6:0] = ops[$urandom_range(8, 0)];
            build(ins, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), rbit(), 0);
            apply($sformatf("rnd%0d", n), ins, -1, pcw, last);
            check_int($sformatf("rnd%0d_one_pc_write", n), pcw, trace.size() - 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
